fusion_stream: RTL and testbench

- Parametrised successor to the frame fusion stage: blends an old and a new frame beat-by-beat using a per-pixel weight map.
- Replaces the fixed-delay shift register and global stall with a frame-pair FIFO, a valid/ready join against an independent weight stream, and a backpressured 2-stage blend pipeline.
- Adds runtime fusion modes and end-of-frame marking.
- Sits between the DMA read path (frame pairs), the similarity/weight engine (weight map) and the write-back path.

---
 rtl/fusion_stream.sv | 185 ++++++++++++++++++
 tb/tb_fusion_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_stream.sv
// Frame fusion stage: frame-pair FIFO joined against a weight stream, 2-stage blend pipeline.
// Optional rounding/saturating blend via `define FUSION_ROUND_EN.
module fusion_stream #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned PIX_W           = 8,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DATA_W          = PIXELS_PER_BEAT * PIX_W
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [1:0]                    mode,
  input  logic                          s_frm_valid,
  output logic                          s_frm_ready,
  input  logic [DATA_W-1:0]             s_old,
  input  logic [DATA_W-1:0]             s_new,
  input  logic                          s_wt_valid,
  output logic                          s_wt_ready,
  input  logic [DATA_W-1:0]             s_wt,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]    LAST_BEAT = CW'(BEATS - 1);
  localparam logic [PIX_W-1:0] PIX_MAX   = '1;
`ifdef FUSION_ROUND_EN
  localparam logic [2*PIX_W:0] HALF = (2*PIX_W+1)'(1) << (PIX_W - 1);
`endif

  typedef enum logic [1:0] {
    MODE_BLEND = 2'd0,
    MODE_GATED = 2'd1,
    MODE_OLD   = 2'd2,
    MODE_NEW   = 2'd3
  } mode_e;

  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_level;
  logic                w_push, w_pop, w_en, w_empty;
  logic [DATA_W-1:0]   w_fifo_old, w_fifo_new;

  assign w_empty     = (r_level == '0);
  assign s_frm_ready = aresetn && (r_level != (AW+1)'(FIFO_DEPTH));
  assign w_push      = s_frm_valid && s_frm_ready;
  assign w_en        = !m_valid || m_ready;
  assign s_wt_ready  = w_en && !w_empty;
  assign w_pop       = s_wt_ready && s_wt_valid;
  assign {w_fifo_old, w_fifo_new} = r_mem[r_rd_ptr];
  assign fifo_level  = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_old, s_new};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  // Mode is captured when beat 0 of a frame pops and rides with the rest of that frame.
  logic [CW-1:0] r_pop_cnt;
  mode_e         r_frame_mode, w_beat_mode;

  assign w_beat_mode = (r_pop_cnt == '0) ? mode_e'(mode) : r_frame_mode;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pop_cnt    <= '0;
      r_frame_mode <= MODE_BLEND;
    end else if (w_pop) begin
      r_pop_cnt <= (r_pop_cnt == LAST_BEAT) ? '0 : r_pop_cnt + CW'(1);
      if (r_pop_cnt == '0) r_frame_mode <= mode_e'(mode);
    end
  end

  logic [2*PIX_W-1:0] w_a [PIXELS_PER_BEAT];
  logic [2*PIX_W-1:0] w_b [PIXELS_PER_BEAT];
  logic [2*PIX_W-1:0] r_a [PIXELS_PER_BEAT];
  logic [2*PIX_W-1:0] r_b [PIXELS_PER_BEAT];
  logic [DATA_W-1:0]  r_old1, r_new1, r_d1;
  logic               r_v1;
  mode_e              r_mode1;

  always_comb begin
    for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
      w_a[i] = (2*PIX_W)'(w_fifo_old[i*PIX_W +: PIX_W]) * (2*PIX_W)'(PIX_MAX - s_wt[i*PIX_W +: PIX_W]);
      w_b[i] = (2*PIX_W)'(w_fifo_new[i*PIX_W +: PIX_W]) * (2*PIX_W)'(s_wt[i*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      r_old1  <= '0;
      r_new1  <= '0;
      r_d1    <= '0;
      r_v1    <= 1'b0;
      r_mode1 <= MODE_BLEND;
    end else if (w_en) begin
      for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
        r_a[i] <= w_a[i];
        r_b[i] <= w_b[i];
      end
      r_old1  <= w_fifo_old;
      r_new1  <= w_fifo_new;
      r_d1    <= s_wt;
      r_v1    <= w_pop;
      r_mode1 <= w_beat_mode;
    end
  end

  logic [2*PIX_W:0]  w_z     [PIXELS_PER_BEAT];
  logic [PIX_W-1:0]  w_blend [PIXELS_PER_BEAT];
`ifdef FUSION_ROUND_EN
  logic [PIX_W:0]    w_q     [PIXELS_PER_BEAT];
`endif
  logic [DATA_W-1:0] w_fused;

  always_comb begin
    w_fused = '0;
    for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
      w_z[i] = {1'b0, r_a[i]} + {1'b0, r_b[i]};
`ifdef FUSION_ROUND_EN
      w_q[i]     = (PIX_W+1)'((w_z[i] + HALF) >> PIX_W);
      w_blend[i] = w_q[i][PIX_W] ? PIX_MAX : w_q[i][PIX_W-1:0];
`else
      w_blend[i] = PIX_W'(w_z[i] >> PIX_W);
`endif
      case (r_mode1)
        MODE_BLEND: w_fused[i*PIX_W +: PIX_W] = w_blend[i];
        MODE_GATED: w_fused[i*PIX_W +: PIX_W] = (r_d1[i*PIX_W +: PIX_W] == '0) ?
                                                r_old1[i*PIX_W +: PIX_W] : w_blend[i];
        MODE_OLD:   w_fused[i*PIX_W +: PIX_W] = r_old1[i*PIX_W +: PIX_W];
        MODE_NEW:   w_fused[i*PIX_W +: PIX_W] = r_new1[i*PIX_W +: PIX_W];
        default:    w_fused[i*PIX_W +: PIX_W] = w_blend[i];
      endcase
    end
  end

  // Index of the beat being loaded into the output register: if the current
  // beat is handing off this cycle, the new one is the next count.
  logic [CW-1:0] r_out_cnt, w_cnt_nxt;
  logic          w_out_hs;

  assign w_out_hs  = m_valid && m_ready;
  assign w_cnt_nxt = !w_out_hs ? r_out_cnt :
                     (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + CW'(1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_cnt <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      r_out_cnt <= w_cnt_nxt;
      if (w_en) begin
        m_valid <= r_v1;
        if (r_v1) begin
          m_data <= w_fused;
          m_last <= (w_cnt_nxt == LAST_BEAT);
        end
      end
    end
  end

endmodule

// File: tb/tb_fusion_stream.sv
// Directed bench for fusion_stream: per-mode vectors, FIFO fill/drain, backpressured frames, reset.
module tb_fusion_stream;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 128;
  localparam int unsigned FRAME = 16384;
  localparam int unsigned TOTAL = 2 * FRAME + 64;
  localparam int unsigned OUT_TARGET = 2 * FRAME + 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [1:0]    mode;
  logic          s_frm_valid, s_frm_ready;
  logic [DW-1:0] s_old, s_new, s_wt;
  logic          s_wt_valid, s_wt_ready;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [4:0]    fifo_level;

  int n_assert = 0;
  int n_fail   = 0;

  fusion_stream dut (
    .clk(clk), .aresetn(aresetn), .mode(mode),
    .s_frm_valid(s_frm_valid), .s_frm_ready(s_frm_ready),
    .s_old(s_old), .s_new(s_new),
    .s_wt_valid(s_wt_valid), .s_wt_ready(s_wt_ready), .s_wt(s_wt),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [7:0] blend_ref(input logic [7:0] o, input logic [7:0] n, input logic [7:0] d);
    int unsigned z;
    z = int'(o) * (255 - int'(d)) + int'(n) * int'(d);
`ifdef FUSION_ROUND_EN
    z = (z + 128) >> 8;
    if (z > 255) z = 255;
`else
    z = z >> 8;
`endif
    return 8'(z);
  endfunction

  function automatic logic [DW-1:0] fuse_ref(input logic [1:0] md, input logic [DW-1:0] o,
                                             input logic [DW-1:0] n, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      case (md)
        2'd0: r[l*8 +: 8] = blend_ref(o[l*8 +: 8], n[l*8 +: 8], w[l*8 +: 8]);
        2'd1: r[l*8 +: 8] = (w[l*8 +: 8] == 8'd0) ? o[l*8 +: 8] :
                            blend_ref(o[l*8 +: 8], n[l*8 +: 8], w[l*8 +: 8]);
        2'd2: r[l*8 +: 8] = o[l*8 +: 8];
        default: r[l*8 +: 8] = n[l*8 +: 8];
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pat_old(input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(k * 7 + l * 13 + (k >> 8));
    return r;
  endfunction

  function automatic logic [DW-1:0] pat_new(input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(k * 3 + l * 29 + 5);
    return r;
  endfunction

  function automatic logic [DW-1:0] pat_wt(input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(k + l * 17 + (k >> 6));
    return r;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    mode = 2'd0; s_frm_valid = 1'b0; s_wt_valid = 1'b0; m_ready = 1'b0;
    s_old = '0; s_new = '0; s_wt = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_frm_ready", DW'(s_frm_ready), DW'(0));
    chk("rst_wt_ready",  DW'(s_wt_ready),  DW'(0));
    chk("rst_m_valid",   DW'(m_valid),     DW'(0));
    chk("rst_m_last",    DW'(m_last),      DW'(0));
    chk("rst_m_data",    m_data,           DW'(0));
    chk("rst_level",     DW'(fifo_level),  DW'(0));
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  // One frame-pair beat offered alongside its weight; fused result lands two edges after the pop.
  task automatic single_beat(input string tag, input logic [1:0] md, input logic [DW-1:0] o,
                             input logic [DW-1:0] n, input logic [DW-1:0] w, input logic [DW-1:0] exp);
    do_reset();
    mode = md; m_ready = 1'b1;
    s_frm_valid = 1'b1; s_old = o; s_new = n;
    s_wt_valid = 1'b1;  s_wt = w;
    #1 chk({tag, "_wt_ready_empty"}, DW'(s_wt_ready), DW'(0));
    @(posedge clk);
    @(negedge clk);
    s_frm_valid = 1'b0;
    chk({tag, "_level1"}, DW'(fifo_level), DW'(1));
    #1 chk({tag, "_wt_ready"}, DW'(s_wt_ready), DW'(1));
    @(posedge clk);
    @(negedge clk);
    s_wt_valid = 1'b0;
    chk({tag, "_level0"}, DW'(fifo_level), DW'(0));
    chk({tag, "_valid_early"}, DW'(m_valid), DW'(0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, DW'(m_valid), DW'(1));
    chk({tag, "_data"}, m_data, exp);
  endtask

  initial begin
    int idx, fi, wi, oi, cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          frm_hs, wt_hs;

    // Directed per-mode vectors
`ifdef FUSION_ROUND_EN
    single_beat("blend_80",  2'd0, rep(8'h10), rep(8'hF0), rep(8'h80), rep(8'h80));
    single_beat("blend_ex2", 2'd0, rep(8'd100), rep(8'd200), rep(8'd128), rep(8'd150));
`else
    single_beat("blend_80",  2'd0, rep(8'h10), rep(8'hF0), rep(8'h80), rep(8'h7F));
    single_beat("blend_ex2", 2'd0, rep(8'd100), rep(8'd200), rep(8'd128), rep(8'd149));
`endif
    single_beat("blend_ff",  2'd0, rep(8'h00), rep(8'hFF), rep(8'hFF), rep(8'hFE));
    single_beat("gated",     2'd1, rep(8'h40), rep(8'hC0), {8{8'hFF, 8'h00}}, {8{8'hBF, 8'h40}});
    single_beat("pass_old",  2'd2, rep(8'h40), rep(8'hC0), {8{8'hFF, 8'h00}}, rep(8'h40));
    single_beat("pass_new",  2'd3, rep(8'h40), rep(8'hC0), {8{8'hFF, 8'h00}}, rep(8'hC0));

    // FIFO fill with weights withheld, then ordered drain
    do_reset();
    mode = 2'd2; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_frm_valid = 1'b1; s_old = rep(8'(i + 1)); s_new = '0;
      @(posedge clk);
      @(negedge clk);
    end
    s_frm_valid = 1'b0;
    chk("full_frm_ready", DW'(s_frm_ready), DW'(0));
    chk("full_level",     DW'(fifo_level),  DW'(16));
    chk("full_no_output", DW'(m_valid),     DW'(0));
    s_wt_valid = 1'b1; s_wt = '0;
    @(posedge clk);
    @(negedge clk);
    chk("drain_ready_back", DW'(s_frm_ready), DW'(1));
    chk("drain_level15",    DW'(fifo_level),  DW'(15));
    idx = 0;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      if (m_valid) begin
        chk("drain_order", m_data, rep(8'(idx + 1)));
        idx++;
      end
      @(negedge clk);
    end
    chk("drain_count", DW'(idx), DW'(16));
    chk("drain_level_end", DW'(fifo_level), DW'(0));
    s_wt_valid = 1'b0;

    // Two full frames plus a partial: random backpressure, mode change mid-frame, reset mid-frame
    do_reset();
    fi = 0; wi = 0; oi = 0; prev_stall = 1'b0; prev_data = '0;
    cyc = 0;
    while (oi < int'(OUT_TARGET) && cyc < 70000) begin
      if (prev_stall) chk("stall_stable", m_data, prev_data);
      m_ready     = (oi < int'(FRAME)) ? ($urandom_range(3) != 0) : 1'b1;
      s_frm_valid = (fi < int'(TOTAL));
      s_old       = pat_old(fi);
      s_new       = pat_new(fi);
      s_wt_valid  = (wi < int'(TOTAL)) && ((oi >= int'(FRAME)) || ($urandom_range(7) != 0));
      s_wt        = pat_wt(wi);
      #1;
      if (m_valid && m_ready) begin
        chk("stream_data", m_data,
            fuse_ref((oi >= int'(2 * FRAME)) ? 2'd3 : 2'd0, pat_old(oi), pat_new(oi), pat_wt(oi)));
        chk("stream_last", DW'(m_last), DW'((oi % int'(FRAME)) == int'(FRAME) - 1));
        oi++;
      end
      frm_hs = s_frm_valid && s_frm_ready;
      wt_hs  = s_wt_valid && s_wt_ready;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (oi == int'(FRAME) + 100) mode = 2'd3;
      @(posedge clk);
      if (frm_hs) fi++;
      if (wt_hs)  wi++;
      @(negedge clk);
      cyc++;
    end
    chk("stream_done", DW'(oi), DW'(OUT_TARGET));

    aresetn = 1'b0;
    #1;
    chk("midrst_valid", DW'(m_valid),     DW'(0));
    chk("midrst_last",  DW'(m_last),      DW'(0));
    chk("midrst_level", DW'(fifo_level),  DW'(0));
    chk("midrst_ready", DW'(s_frm_ready), DW'(0));
    s_frm_valid = 1'b0; s_wt_valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_valid", DW'(m_valid),    DW'(0));
    chk("post_rst_level", DW'(fifo_level), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
